// File: rtl/debug_sequencer.sv
// Purpose: debug sequencer between the host byte link and the MIPS pipeline; gates pipeline advance and streams PC + register snapshots.
// Latency: 'd' accepted at N -> snapshot at N+1, first byte at N+2; 's' adds one enabled pipeline cycle ahead of the snapshot.
// Backpressure: o_tx_valid/i_tx_ready per byte; data and counter hold while stalled; commands stay pending (o_cmd_ready=0) while busy.
module debug_sequencer #(
    parameter int PC_BITS   = 32,
    parameter int PROC_BITS = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_cmd_valid,
    input  logic [7:0]                    i_cmd,
    output logic                          o_cmd_ready,
    input  logic                          i_halt,
    input  logic [PC_BITS-1:0]            i_pc,
    input  logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs,
    output logic                          o_pipe_enable,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic                          o_halted
);

    localparam int         REG_BYTES   = PROC_BITS / 8;
    localparam int         TOTAL_BYTES = 4 + NUM_REGS * REG_BYTES;
    localparam int         SNAP_BITS   = TOTAL_BYTES * 8;
    localparam logic [7:0] LAST_IDX    = 8'(TOTAL_BYTES - 1);

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SEND
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SNAP_BITS-1:0]   snap_q;
    logic [SNAP_BITS-1:0]   snap_load;
    logic [7:0]             byte_cnt;
    logic                   halted_q;
    logic                   halt_hit;

    // Transmit image: PC in the top word, then reg0..regN-1, so shifting left by a byte walks the stream in order.
    always_comb begin
        snap_load = '0;
        snap_load[SNAP_BITS-1 -: 32] = 32'(i_pc);
        for (int k = 0; k < NUM_REGS; k++) begin
            snap_load[(NUM_REGS-1-k)*PROC_BITS +: PROC_BITS] = i_rf_regs[k*PROC_BITS +: PROC_BITS];
        end
    end

    // Next-state and per-state outputs; halt masks the enable in the same cycle it is seen.
    always_comb begin
        state_nxt     = state;
        o_cmd_ready   = 1'b0;
        o_pipe_enable = 1'b0;
        o_tx_valid    = 1'b0;
        halt_hit      = 1'b0;
        case (state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    case (i_cmd)
                        CMD_RUN:  if (!halted_q) state_nxt = ST_RUN;
                        CMD_STEP: if (!halted_q) state_nxt = ST_STEP;
                        CMD_DUMP: state_nxt = ST_SNAP;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    halt_hit  = 1'b1;
                    state_nxt = ST_SNAP;
                end else begin
                    o_pipe_enable = 1'b1;
                end
            end
            ST_STEP: begin
                o_pipe_enable = !i_halt;
                halt_hit      = i_halt;
                state_nxt     = ST_SNAP;
            end
            ST_SNAP: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                o_tx_valid = 1'b1;
                if (i_tx_ready && (byte_cnt == LAST_IDX)) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any dump in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Snapshot capture and byte stream shifter; holds while the sink stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q   <= '0;
            byte_cnt <= '0;
        end else if (state == ST_SNAP) begin
            snap_q   <= snap_load;
            byte_cnt <= '0;
        end else if (o_tx_valid && i_tx_ready) begin
            snap_q   <= snap_q << 8;
            byte_cnt <= byte_cnt + 8'd1;
        end
    end

    // Sticky halted flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          halted_q <= 1'b0;
        else if (halt_hit) halted_q <= 1'b1;
    end

    assign o_tx_data = snap_q[SNAP_BITS-1 -: 8];
    assign o_busy    = (state != ST_IDLE);
    assign o_halted  = halted_q;

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Sits between the host byte link (UART RX/TX) and the MIPS pipeline.
- Gates pipeline advance via o_pipe_enable:
  - continuous run until a HALT instruction retires, or
  - single step, one clock.
- After a run ends or a step completes, streams a snapshot of PC and all register-file contents to the host as bytes over a valid/ready handshake.
- On command, dumps the snapshot without advancing the pipeline.

Parameters:
- PC_BITS, 32, width of i_pc.
- PROC_BITS, 32, register width; must be a multiple of 8.
- NUM_REGS, 32, number of registers in i_rf_regs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  host command byte present.
- i_cmd  in  8  command byte.
- o_cmd_ready  out  1  command accepted this cycle when high with i_cmd_valid.
- i_halt  in  1  HALT instruction reached WB; level, sampled each cycle.
- i_pc  in  PC_BITS  current PC.
- i_rf_regs  in  NUM_REGS*PROC_BITS  flattened register file; reg k at bits [k*PROC_BITS +: PROC_BITS].
- o_pipe_enable  out  1  pipeline advances on clock edges where high.
- o_tx_data  out  8  byte to host.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  sink accepts byte.
- o_busy  out  1  high in any state except IDLE.
- o_halted  out  1  sticky; program has halted.

Behaviour:
- Commands: 0x63 'c' = RUN, 0x73 's' = STEP, 0x64 'd' = DUMP; any other byte is consumed and ignored.
- States: IDLE, RUN, STEP, SNAP, SEND.
- IDLE:
  - o_cmd_ready=1; a command is taken on i_cmd_valid&o_cmd_ready.
  - 'c' -> RUN; 's' -> STEP; 'd' -> SNAP.
  - If o_halted=1, 'c' and 's' are consumed and ignored (stay IDLE); 'd' is still honoured.
- RUN:
  - o_pipe_enable=1 every cycle while i_halt=0.
  - When i_halt=1: o_pipe_enable=0 that same cycle (combinational), o_halted set, next state SNAP.
  - Commands are not accepted (o_cmd_ready=0).
- STEP:
  - Exactly one cycle, o_pipe_enable=1, -> SNAP.
  - If i_halt=1 during STEP: o_pipe_enable=0 and o_halted set.
- SNAP:
  - One cycle: latch i_pc and i_rf_regs into an internal snapshot register, clear byte counter -> SEND.
  - Later changes on inputs do not affect bytes sent.
- SEND:
  - Emits 4 + 4*NUM_REGS = 132 bytes by default, order: PC then reg0..reg31, each word MSB byte first.
  - PC is zero-extended/truncated to 32 bits.
  - o_tx_valid=1; a byte transfers on o_tx_valid&i_tx_ready; counter increments per transfer.
  - o_tx_data must hold stable while o_tx_valid=1 and i_tx_ready=0.
  - After the transfer of byte 131, next cycle: IDLE, o_tx_valid=0.
  - Counter is 8 bits; no wrap within one dump.
- o_pipe_enable is 0 in IDLE, SNAP and SEND.
- o_tx_valid is 0 outside SEND.
- Reset (rst=0), asynchronous, any state including mid-SEND:
  - state=IDLE, o_pipe_enable=0, o_tx_valid=0, o_tx_data=0, o_halted=0, o_busy=0, counter=0, snapshot=0.
  - o_cmd_ready=1 once reset is released.
  - A partial dump is abandoned, not resumed.
- Simultaneous events:
  - i_halt=1 on the first RUN cycle -> zero enabled cycles, dump follows.
  - i_cmd_valid in a non-IDLE state is left pending, not dropped; it is taken on return to IDLE.
- Latency:
  - 'd' accepted at cycle N -> SNAP at N+1, first o_tx_valid at N+2.
  - 's' -> enable at N+1, SNAP at N+2, first byte at N+3.

Test Plan:
- Reset mid-SEND: after 10 bytes transferred, pulse rst=0 for 1 cycle -> o_tx_valid=0 asynchronously, state IDLE; then 'd' gives a full fresh 132-byte dump.
- DUMP, i_tx_ready=1 always:
  - Stimulus: i_pc=0x00000008, reg k=k*10, send 'd'.
  - Required: exactly 132 bytes; byte0..3 = 00 00 00 08; reg1 bytes = 00 00 00 0A; reg31 bytes = 00 00 01 36; o_pipe_enable never high; o_busy drops after the last byte.
- Backpressure:
  - Stimulus: i_tx_ready toggling 1,0,0,1..., with a ready=0 stretch of 5 cycles.
  - Required: o_tx_data stable through the stretch; byte sequence identical to the previous test; total 132 transfers.
- STEP:
  - Stimulus: send 's' three times, each after the dump completes.
  - Required: o_pipe_enable high for exactly 1 cycle per command (3 total), each followed by a 132-byte dump.
- RUN to HALT:
  - Stimulus: send 'c'; assert i_halt at the 20th enabled cycle.
  - Required: o_pipe_enable high exactly 19 cycles, low on the halt cycle; o_halted=1; dump follows; a subsequent 'c' is consumed with no enable; a subsequent 'd' dumps.
- Ignored and queued commands:
  - Send 0x41 -> consumed, stays IDLE, no enable and no tx.
  - Hold 'd' valid during SEND -> o_cmd_ready=0 throughout; the command is accepted the first IDLE cycle and a second dump follows.
